alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//   Shares one 32-bit ALU between two requesters, e.g. the execute stage (port 0) and an address/branch unit (port 1).
//   Each port has a valid/ready request channel and a valid/ready response channel.
//   Round-robin arbitration; one registered result slot per port; one-cycle request-to-response latency.
// PARAMETERS
//   N   32   datapath width; only 32 is legal (ALU result select is 32-bit)
// PORTS
//   clk           in   1  single clock; all state updates on rising edge
//   rst_n         in   1  synchronous reset, active-low, sampled on rising clk edge
//   req0_valid    in   1  port 0 request valid
//   req0_ready    out  1  port 0 request accepted this cycle (= grant0)
//   req0_a        in   N  port 0 operand A
//   req0_b        in   N  port 0 operand B
//   req0_op       in   3  port 0 op: 000 add, 001 sub, 010 and, 011 or, 1xx illegal
//   req1_valid / req1_ready / req1_a / req1_b / req1_op   same widths and meanings, port 1
//   rsp0_valid    out  1  port 0 result slot holds an undelivered result
//   rsp0_ready    in   1  port 0 consumer takes result this cycle
//   rsp0_result   out  N  port 0 registered ALU result
//   rsp0_zero     out  1  port 0 registered zero flag
//   rsp1_valid / rsp1_ready / rsp1_result / rsp1_zero      same widths and meanings, port 1
//   last_grant    out  1  index of most recently granted port
//   illegal_op    out  1  sticky illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (rst_n=0 at edge): rsp*_valid=0, rsp*_result=0, rsp*_zero=0, last_grant=1, illegal_op=0.
//     An in-flight result is discarded on reset; reqX_ready=0 during reset.
//   - Eligibility: elig_i = req_i_valid && (!rsp_i_valid || rsp_i_ready).
//     A request is eligible only when its slot is empty or draining this cycle.
//   - Grant (combinational, at most one per cycle):
//       - only one port eligible -> that port;
//       - both eligible -> port != last_grant;
//       - none -> no grant.
//     req_i_ready = grant_i. req_i_ready may depend on req_i_valid; requesters must not wait on ready before asserting valid.
//   - The single ALU input mux selects the granted port's a/b/op; ungranted operands are don't-care.
//   - On grant_i at edge:
//       - rsp_i_result <= ALU(a,b,op), 32-bit wrap-around (add/sub modulo 2^32, no carry out);
//       - rsp_i_zero <= (a == b), independent of op;
//       - rsp_i_valid <= 1; last_grant <= i.
//     Latency: request handshake in cycle T -> rsp_i_valid=1 in cycle T+1.
//   - Drain: rsp_i_valid && rsp_i_ready with no grant_i -> rsp_i_valid <= 0; result/zero keep their last value.
//   - Simultaneous drain + grant on the same port -> rsp_i_valid stays 1 and the new result loads (back-to-back, 1 op/cycle).
//   - Stall: rsp_i_valid && !rsp_i_ready -> result/zero held stable; port i is not granted. The other port keeps full throughput.
//   - No grant -> last_grant unchanged.
//   - Throughput: one ALU op per cycle total across both ports.
// CONFIGURATION
//   ALU_ILLEGAL_OP_CHECK_EN
//     defined: a granted request with op[2]=1 is still accepted and completes normally (valid, latency unchanged), but
//       - rsp_i_result <= 0 and rsp_i_zero <= 0;
//       - illegal_op <= 1, cleared only by reset.
//     undefined: op passes to the ALU unchecked (result X for 1xx); illegal_op tied 0.
// TESTING
//   1 reset: rst_n=0 two cycles, random req/rsp inputs -> all rsp*_valid=0, results 0, last_grant=1, req*_ready=0.
//   2 single op: req0 add a=5 b=7 in cycle T -> rsp0_valid=1 at T+1, result 12, zero 0; rsp0_ready=1 -> valid 0 at T+2.
//   3 contention: both valid every cycle, both rsp_ready=1 -> grants alternate 0,1,0,1; port 1 sub a=b=9 -> result 0, zero 1.
//   4 backpressure: rsp0_ready=0 with rsp0_valid=1 and req0 pending -> req0_ready=0, rsp0 held for 5 cycles;
//     req1 granted every cycle; raising rsp0_ready -> req0 granted that same cycle.
//   5 wrap: add 0xFFFFFFFF+1 -> 0, zero 0; sub 0-1 -> 0xFFFFFFFF.
//   6 illegal (macro on): op=100 -> rsp valid, result 0, illegal_op=1 and stays 1 until reset; macro off -> illegal_op=0.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between two ALU clients and alu_arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface alu_arbiter_if #(parameter int N = 32);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [2:0]   req0_op;
    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req1_op;
    logic         rsp0_valid;
    logic         rsp0_ready;
    logic [N-1:0] rsp0_result;
    logic         rsp0_zero;
    logic         rsp1_valid;
    logic         rsp1_ready;
    logic [N-1:0] rsp1_result;
    logic         rsp1_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        output rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_result, rsp0_zero,
        input  rsp1_valid, rsp1_result, rsp1_zero
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        input  rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_result, rsp0_zero,
        output rsp1_valid, rsp1_result, rsp1_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one 32-bit ALU between two clients, one registered result slot per port.
// Optional macro ALU_ILLEGAL_OP_CHECK_EN: op 1xx yields result 0 / zero 0 and sets sticky o_illegal_op.
module alu_arbiter (
    input  logic         i_clk,
    input  logic         i_rst_n,
    alu_arbiter_if.slave bus,
    output logic         o_last_grant,
    output logic         o_illegal_op
);
    localparam int N = 32;

    logic         w_elig0;
    logic         w_elig1;
    logic         w_grant0;
    logic         w_grant1;
    logic [N-1:0] w_a;
    logic [N-1:0] w_b;
    logic [2:0]   w_op;
    logic [N-1:0] w_alu;
    logic [N-1:0] w_result;
    logic         w_zero;

    logic         r_rsp0_valid;
    logic [N-1:0] r_rsp0_result;
    logic         r_rsp0_zero;
    logic         r_rsp1_valid;
    logic [N-1:0] r_rsp1_result;
    logic         r_rsp1_zero;
    logic         r_last_grant;

    // A port may be granted only if its slot is empty or being emptied this cycle.
    assign w_elig0  = i_rst_n && bus.req0_valid && (!r_rsp0_valid || bus.rsp0_ready);
    assign w_elig1  = i_rst_n && bus.req1_valid && (!r_rsp1_valid || bus.rsp1_ready);
    assign w_grant0 = w_elig0 && (!w_elig1 || r_last_grant);
    assign w_grant1 = w_elig1 && (!w_elig0 || !r_last_grant);

    assign w_a  = w_grant1 ? bus.req1_a  : bus.req0_a;
    assign w_b  = w_grant1 ? bus.req1_b  : bus.req0_b;
    assign w_op = w_grant1 ? bus.req1_op : bus.req0_op;

    always_comb begin
        w_alu = '0;
        case (w_op)
            3'b000:  w_alu = w_a + w_b;
            3'b001:  w_alu = w_a - w_b;
            3'b010:  w_alu = w_a & w_b;
            3'b011:  w_alu = w_a | w_b;
            default: w_alu = 'x;
        endcase
    end

`ifdef ALU_ILLEGAL_OP_CHECK_EN
    logic r_illegal_op;

    assign w_result = w_op[2] ? '0   : w_alu;
    assign w_zero   = w_op[2] ? 1'b0 : (w_a == w_b);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_illegal_op <= 1'b0;
        end else if ((w_grant0 || w_grant1) && w_op[2]) begin
            r_illegal_op <= 1'b1;
        end
    end

    assign o_illegal_op = r_illegal_op;
`else
    assign w_result     = w_alu;
    assign w_zero       = (w_a == w_b);
    assign o_illegal_op = 1'b0;
`endif

    // A grant on a draining slot reloads it, giving one op per cycle per port.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rsp0_valid  <= 1'b0;
            r_rsp0_result <= '0;
            r_rsp0_zero   <= 1'b0;
            r_rsp1_valid  <= 1'b0;
            r_rsp1_result <= '0;
            r_rsp1_zero   <= 1'b0;
            r_last_grant  <= 1'b1;
        end else begin
            if (w_grant0) begin
                r_rsp0_valid  <= 1'b1;
                r_rsp0_result <= w_result;
                r_rsp0_zero   <= w_zero;
            end else if (r_rsp0_valid && bus.rsp0_ready) begin
                r_rsp0_valid  <= 1'b0;
            end

            if (w_grant1) begin
                r_rsp1_valid  <= 1'b1;
                r_rsp1_result <= w_result;
                r_rsp1_zero   <= w_zero;
            end else if (r_rsp1_valid && bus.rsp1_ready) begin
                r_rsp1_valid  <= 1'b0;
            end

            if (w_grant0) begin
                r_last_grant <= 1'b0;
            end else if (w_grant1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    assign bus.req0_ready  = w_grant0;
    assign bus.req1_ready  = w_grant1;
    assign bus.rsp0_valid  = r_rsp0_valid;
    assign bus.rsp0_result = r_rsp0_result;
    assign bus.rsp0_zero   = r_rsp0_zero;
    assign bus.rsp1_valid  = r_rsp1_valid;
    assign bus.rsp1_result = r_rsp1_result;
    assign bus.rsp1_zero   = r_rsp1_zero;
    assign o_last_grant    = r_last_grant;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios then random traffic against a queue-based model.
// Honours ALU_ILLEGAL_OP_CHECK_EN the same way the design does.
module tb_alu_arbiter;
    typedef struct packed {
        logic [31:0] result;
        logic        zero;
    } rsp_t;

    logic clk;
    logic rstN;
    logic lastGrant;
    logic illegalOp;

    int errors = 0;
    int checks = 0;
    bit monitorOn = 0;

    rsp_t expQ0[$];
    rsp_t expQ1[$];
    int   modelLast;
    bit   modelIllegal;

    alu_arbiter_if #(.N(32)) bus ();

    alu_arbiter dut (
        .i_clk        (clk),
        .i_rst_n      (rstN),
        .bus          (bus.slave),
        .o_last_grant (lastGrant),
        .o_illegal_op (illegalOp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison; every mismatch prints a single FAIL line.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference ALU written straight from the op table.
    function automatic rsp_t refAlu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        rsp_t r;
        r.zero = (a == b);
        case (op)
            3'd0:    r.result = a + b;
            3'd1:    r.result = a - b;
            3'd2:    r.result = a & b;
            3'd3:    r.result = a | b;
            default: begin r.result = 32'd0; r.zero = 1'b0; end
        endcase
        return r;
    endfunction

    // Drive one cycle of inputs, shortly after the rising edge.
    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                                 input logic v1, input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                                 input logic rr0, input logic rr1);
        @(posedge clk);
        #1;
        bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0; bus.req0_op = op0;
        bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1; bus.req1_op = op1;
        bus.rsp0_ready = rr0; bus.rsp1_ready = rr1;
    endtask

    task automatic randomInputs(input bit allowIllegal);
        logic [31:0] a0, b0, a1, b1;
        logic [2:0]  op0, op1;
        b0 = $urandom; a0 = ($urandom_range(0, 3) == 0) ? b0 : $urandom;
        b1 = $urandom; a1 = ($urandom_range(0, 3) == 0) ? b1 : $urandom;
        op0 = 3'($urandom_range(0, 3));
        op1 = 3'($urandom_range(0, 3));
        if (allowIllegal && $urandom_range(0, 15) == 0) op0 = 3'($urandom_range(4, 7));
        if (allowIllegal && $urandom_range(0, 15) == 0) op1 = 3'($urandom_range(4, 7));
        applyStimulus($urandom_range(0, 3) != 0, a0, b0, op0,
                      $urandom_range(0, 3) != 0, a1, b1, op1,
                      $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7);
    endtask

    // Hold reset for two edges under random traffic, check the reset state, then release.
    task automatic doReset();
        @(posedge clk);
        #1;
        monitorOn = 0;
        rstN = 1'b0;
        repeat (2) randomInputs(1'b1);
        @(negedge clk);
        checkOutput("reset req0_ready", 32'(bus.req0_ready), 32'd0);
        checkOutput("reset req1_ready", 32'(bus.req1_ready), 32'd0);
        checkOutput("reset rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        checkOutput("reset rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        checkOutput("reset rsp0_result", bus.rsp0_result, 32'd0);
        checkOutput("reset rsp1_result", bus.rsp1_result, 32'd0);
        checkOutput("reset rsp0_zero", 32'(bus.rsp0_zero), 32'd0);
        checkOutput("reset rsp1_zero", 32'(bus.rsp1_zero), 32'd0);
        checkOutput("reset last_grant", 32'(lastGrant), 32'd1);
        checkOutput("reset illegal_op", 32'(illegalOp), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstN = 1'b1;
        expQ0.delete();
        expQ1.delete();
        modelLast = 1;
        modelIllegal = 0;
        monitorOn = 1;
    endtask

    bit   mElig0, mElig1, mGrant0, mGrant1;
    rsp_t mExp;

    // Monitor: predicts grants from slot occupancy, compares held results, pops on drain, pushes on grant.
    always @(negedge clk) begin
        if (monitorOn) begin
            mElig0  = bus.req0_valid && (expQ0.size() == 0 || bus.rsp0_ready);
            mElig1  = bus.req1_valid && (expQ1.size() == 0 || bus.rsp1_ready);
            mGrant0 = mElig0 && (!mElig1 || modelLast == 1);
            mGrant1 = mElig1 && (!mElig0 || modelLast == 0);

            checkOutput("req0_ready", 32'(bus.req0_ready), 32'(mGrant0));
            checkOutput("req1_ready", 32'(bus.req1_ready), 32'(mGrant1));
            checkOutput("rsp0_valid", 32'(bus.rsp0_valid), 32'(expQ0.size() != 0));
            checkOutput("rsp1_valid", 32'(bus.rsp1_valid), 32'(expQ1.size() != 0));
            checkOutput("last_grant", 32'(lastGrant), 32'(modelLast));
            checkOutput("illegal_op", 32'(illegalOp), 32'(modelIllegal));

            if (expQ0.size() != 0) begin
                mExp = expQ0[0];
                checkOutput("rsp0_result", bus.rsp0_result, mExp.result);
                checkOutput("rsp0_zero", 32'(bus.rsp0_zero), 32'(mExp.zero));
                if (bus.rsp0_ready) void'(expQ0.pop_front());
            end
            if (expQ1.size() != 0) begin
                mExp = expQ1[0];
                checkOutput("rsp1_result", bus.rsp1_result, mExp.result);
                checkOutput("rsp1_zero", 32'(bus.rsp1_zero), 32'(mExp.zero));
                if (bus.rsp1_ready) void'(expQ1.pop_front());
            end

            if (mGrant0) begin
                expQ0.push_back(refAlu(bus.req0_a, bus.req0_b, bus.req0_op));
                modelLast = 0;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
                if (bus.req0_op[2]) modelIllegal = 1;
`endif
            end
            if (mGrant1) begin
                expQ1.push_back(refAlu(bus.req1_a, bus.req1_b, bus.req1_op));
                modelLast = 1;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
                if (bus.req1_op[2]) modelIllegal = 1;
`endif
            end
        end
    end

    initial begin
        bit illegalAllowed;
`ifdef ALU_ILLEGAL_OP_CHECK_EN
        illegalAllowed = 1;
`else
        illegalAllowed = 0;
`endif
        rstN = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        doReset();

        // Single add, drained the following cycle.
        applyStimulus(1, 32'd5, 32'd7, 3'd0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Contention: both ports every cycle, port 1 subtracts equal operands.
        for (int i = 0; i < 6; i++)
            applyStimulus(1, 32'(i), 32'd3, 3'd2, 1, 32'd9, 32'd9, 3'd1, 1, 1);

        // Port 0 consumer stalls for several cycles, then recovers.
        applyStimulus(1, 32'd10, 32'd20, 3'd3, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1, 32'd11, 32'd22, 3'd0, 1, 32'(100 + i), 32'd1, 3'd1, 0, 1);
        applyStimulus(1, 32'd11, 32'd22, 3'd0, 1, 32'd200, 32'd1, 3'd0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        // Wrap-around at both ends of the 32-bit range.
        applyStimulus(1, 32'hFFFF_FFFF, 32'd1, 3'd0, 1, 32'd0, 32'd1, 3'd1, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);

        if (illegalAllowed) begin
            applyStimulus(1, 32'd4, 32'd4, 3'b100, 0, 0, 0, 0, 1, 1);
            for (int i = 0; i < 4; i++)
                applyStimulus(1, 32'(i), 32'd1, 3'd0, 1, 32'd2, 32'd2, 3'd1, 1, 1);
        end

        for (int i = 0; i < 3000; i++) randomInputs(illegalAllowed);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        doReset();
        for (int i = 0; i < 200; i++) randomInputs(illegalAllowed);

        @(negedge clk);
        monitorOn = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
